lsu_misalign_splitter: RTL

//  Sits between the MEM-stage pipeline register and data_mem and drives data_mem's address, write-data, write-enable,

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_misalign_splitter_if.sv | 36 +++
 rtl/lsu_load_extend.sv | 28 ++
 rtl/lsu_misalign_splitter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the LSU misalignment splitter.
// Size codes match data_mem store_size / load_size.
package lsu_pkg;

  localparam logic [1:0] SSIZE_B  = 2'b00;
  localparam logic [1:0] SSIZE_H  = 2'b01;
  localparam logic [1:0] SSIZE_W  = 2'b10;

  localparam logic [2:0] LSIZE_B  = 3'b000;
  localparam logic [2:0] LSIZE_H  = 3'b001;
  localparam logic [2:0] LSIZE_W  = 3'b010;
  localparam logic [2:0] LSIZE_BU = 3'b100;
  localparam logic [2:0] LSIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    SPLIT,
    DONE
  } lsu_state_t;

  function automatic logic is_half(
    input logic       we,
    input logic [1:0] ssize,
    input logic [2:0] lsize
  );
    return we ? (ssize == SSIZE_H)
              : (lsize == LSIZE_H || lsize == LSIZE_HU);
  endfunction

  function automatic logic is_word(
    input logic       we,
    input logic [1:0] ssize,
    input logic [2:0] lsize
  );
    return we ? (ssize == SSIZE_W) : (lsize == LSIZE_W);
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] addr_lo,
    input logic [1:0] ssize,
    input logic [2:0] lsize,
    input logic       we
  );
    return (is_half(we, ssize, lsize) && addr_lo[0])
        || (is_word(we, ssize, lsize) && addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_misalign_splitter_if.sv
// MEM-stage request bus plus the data_mem side of the splitter.
// master = pipeline/data_mem environment, slave = splitter.
interface lsu_misalign_splitter_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_ssize;
  logic [2:0]      req_lsize;
  logic            flush;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_we;
  logic [1:0]      mem_ssize;
  logic [2:0]      mem_lsize;
  logic [XLEN-1:0] mem_rdata;
  logic            stall;
  logic [XLEN-1:0] load_data;
  logic            misalign_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output req_ssize, req_lsize, flush, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_ssize,
    input  mem_lsize, stall, load_data, misalign_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  req_ssize, req_lsize, flush, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_ssize,
    output mem_lsize, stall, load_data, misalign_err
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled load value by load size.
// Word and unknown codes pass through unchanged.
module lsu_load_extend #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      lsize,
  output logic [XLEN-1:0] ext
);
  import lsu_pkg::*;

  always_comb begin
    ext = raw;
    unique case (1'b1)
      (lsize == LSIZE_B):
        ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      (lsize == LSIZE_H):
        ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      (lsize == LSIZE_BU):
        ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      (lsize == LSIZE_HU):
        ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      default:
        ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_misalign_splitter.sv
// Aligned accesses pass straight to data_mem; misaligned half/word
// accesses are replayed as byte accesses while the pipeline stalls.
module lsu_misalign_splitter #(
  parameter int XLEN           = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  lsu_misalign_splitter_if.slave bus
);
  import lsu_pkg::*;

  lsu_state_t      state_q;
  lsu_state_t      state_d;
  logic [1:0]      idx_q;
  logic [1:0]      last_q;
  logic [XLEN-1:0] base_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] ext;
  logic            we_q;
  logic [2:0]      lsize_q;
  logic            mis;
  logic            latch;
  logic [4:0]      sh;

  assign mis = bus.req_valid
             & is_misaligned(bus.req_addr[1:0], bus.req_ssize,
                             bus.req_lsize, bus.req_we);
  assign sh  = {idx_q, 3'b000};

  lsu_load_extend #(.XLEN(XLEN)) u_ext (
    .raw   (acc_q),
    .lsize (lsize_q),
    .ext   (ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      base_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      lsize_q <= LSIZE_B;
    end else if (latch) begin
      idx_q   <= 2'd0;
      base_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      acc_q   <= '0;
      we_q    <= bus.req_we;
      lsize_q <= bus.req_lsize;
      last_q  <= is_word(bus.req_we, bus.req_ssize, bus.req_lsize)
                 ? 2'd3 : 2'd1;
    end else if (state_q == SPLIT) begin
      idx_q <= idx_q + 2'd1;
      if (!we_q) acc_q[sh +: 8] <= bus.mem_rdata[7:0];
    end
  end

  always_comb begin
    state_d          = state_q;
    latch            = 1'b0;
    bus.mem_addr     = bus.req_addr;
    bus.mem_wdata    = bus.req_wdata;
    bus.mem_we       = 1'b0;
    bus.mem_ssize    = bus.req_ssize;
    bus.mem_lsize    = bus.req_lsize;
    bus.stall        = 1'b0;
    bus.load_data    = '0;
    bus.misalign_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mis) begin
          bus.mem_we    = bus.req_valid & bus.req_we;
          bus.load_data = bus.mem_rdata;
        end else if (!bus.flush) begin
          if (ALLOW_MISALIGN) begin
            latch     = 1'b1;
            bus.stall = 1'b1;
            state_d   = SPLIT;
          end else begin
            bus.misalign_err = 1'b1;
          end
        end
      end
      SPLIT: begin
        bus.mem_addr  = base_q + XLEN'(idx_q);
        bus.mem_wdata = {{(XLEN-8){1'b0}}, wdata_q[sh +: 8]};
        bus.mem_we    = we_q;
        bus.mem_ssize = SSIZE_B;
        bus.mem_lsize = LSIZE_BU;
        bus.stall     = 1'b1;
        if (idx_q == last_q) state_d = DONE;
      end
      DONE: begin
        bus.load_data = ext;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a killed request must not touch memory; already-written bytes stay
    if (bus.flush) begin
      bus.mem_we = 1'b0;
      state_d    = IDLE;
    end
    if (rst) begin
      bus.mem_we       = 1'b0;
      bus.stall        = 1'b0;
      bus.load_data    = '0;
      bus.misalign_err = 1'b0;
    end
  end

endmodule
